// File: rtl/tx_resp_sched_if.sv
// tx_resp_sched_if: response-source, TX FIFO write and status bundle.
// master drives sources/FIFO_FULL; slave is the scheduler side.
interface tx_resp_sched_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0]   RD_DATA;
  logic                RD_DATA_VALID;
  logic [2*DATA_W-1:0] ALU_OUT;
  logic                ALU_OUT_VALID;
  logic                FIFO_FULL;
  logic [DATA_W-1:0]   TX_P_DATA;
  logic                TX_DATA_VALID;
  logic                RD_BUSY;
  logic                ALU_BUSY;
  logic                DROP_ERR;

  modport master (
    output RD_DATA, RD_DATA_VALID,
    output ALU_OUT, ALU_OUT_VALID,
    output FIFO_FULL,
    input  TX_P_DATA, TX_DATA_VALID,
    input  RD_BUSY, ALU_BUSY, DROP_ERR
  );

  modport slave (
    input  RD_DATA, RD_DATA_VALID,
    input  ALU_OUT, ALU_OUT_VALID,
    input  FIFO_FULL,
    output TX_P_DATA, TX_DATA_VALID,
    output RD_BUSY, ALU_BUSY, DROP_ERR
  );
endinterface

// File: rtl/tx_resp_sched.sv
// tx_resp_sched: round-robin scheduler of RD (1 byte) / ALU (2 bytes, LSB
// first) responses onto the TX FIFO write port. Ports: CLK, RST, bus.slave.
module tx_resp_sched #(
  parameter int DATA_W = 8
) (
  input  logic           CLK,
  input  logic           RST,
  tx_resp_sched_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    SEND_RD,
    SEND_ALU_LO,
    SEND_ALU_HI
  } state_e;

  state_e              state;
  state_e              state_nxt;
  logic                last_alu;
  logic                last_nxt;
  logic                rd_vld;
  logic [DATA_W-1:0]   rd_q;
  logic                alu_vld;
  logic [2*DATA_W-1:0] alu_q;
  logic                drop_err;
  logic                tx_vld;
  logic [DATA_W-1:0]   tx_dat;
  logic                rd_clr;
  logic                alu_clr;
  logic                rd_load;
  logic                alu_load;
  logic                rd_drop;
  logic                alu_drop;

  // A slot releasing on this edge may take a new strobe.
  assign rd_load  = bus.RD_DATA_VALID & (~rd_vld | rd_clr);
  assign alu_load = bus.ALU_OUT_VALID & (~alu_vld | alu_clr);
  assign rd_drop  = bus.RD_DATA_VALID & rd_vld & ~rd_clr;
  assign alu_drop = bus.ALU_OUT_VALID & alu_vld & ~alu_clr;

  always_comb begin
    state_nxt = state;
    last_nxt  = last_alu;
    tx_vld    = 1'b0;
    tx_dat    = '0;
    rd_clr    = 1'b0;
    alu_clr   = 1'b0;
    case (state)
      IDLE: begin
        case ({rd_vld, alu_vld})
          2'b11: begin
            if (last_alu) begin
              state_nxt = SEND_RD;
              last_nxt  = 1'b0;
            end else begin
              state_nxt = SEND_ALU_LO;
              last_nxt  = 1'b1;
            end
          end
          2'b10: begin
            state_nxt = SEND_RD;
            last_nxt  = 1'b0;
          end
          2'b01: begin
            state_nxt = SEND_ALU_LO;
            last_nxt  = 1'b1;
          end
          default: ;
        endcase
      end
      SEND_RD: begin
        tx_vld = ~bus.FIFO_FULL;
        tx_dat = rd_q;
        if (tx_vld) begin
          state_nxt = IDLE;
          rd_clr    = 1'b1;
        end
      end
      SEND_ALU_LO: begin
        tx_vld = ~bus.FIFO_FULL;
        tx_dat = alu_q[DATA_W-1:0];
        if (tx_vld) begin
          state_nxt = SEND_ALU_HI;
        end
      end
      SEND_ALU_HI: begin
        tx_vld = ~bus.FIFO_FULL;
        tx_dat = alu_q[2*DATA_W-1:DATA_W];
        if (tx_vld) begin
          state_nxt = IDLE;
          alu_clr   = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      last_alu <= 1'b1;
      rd_vld   <= 1'b0;
      rd_q     <= '0;
      alu_vld  <= 1'b0;
      alu_q    <= '0;
      drop_err <= 1'b0;
    end else begin
      state    <= state_nxt;
      last_alu <= last_nxt;
      drop_err <= rd_drop | alu_drop;
      if (rd_load) begin
        rd_vld <= 1'b1;
        rd_q   <= bus.RD_DATA;
      end else if (rd_clr) begin
        rd_vld <= 1'b0;
      end
      if (alu_load) begin
        alu_vld <= 1'b1;
        alu_q   <= bus.ALU_OUT;
      end else if (alu_clr) begin
        alu_vld <= 1'b0;
      end
    end
  end

  assign bus.TX_P_DATA     = tx_dat;
  assign bus.TX_DATA_VALID = tx_vld;
  assign bus.RD_BUSY       = rd_vld;
  assign bus.ALU_BUSY      = alu_vld;
  assign bus.DROP_ERR      = drop_err;

endmodule

// File: tb/tb_tx_resp_sched.sv
// tb_tx_resp_sched: vector table, hand-written corner sequences and
// random stimulus against a byte-queue reference model.
module tb_tx_resp_sched;

  logic CLK = 1'b0;
  logic RST = 1'b1;

  always #5 CLK = ~CLK;

  tx_resp_sched_if #(.DATA_W(8)) bus ();

  tx_resp_sched #(.DATA_W(8)) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  bit use_model = 1'b0;

  logic       o_txv;
  logic [7:0] o_txd;
  logic       o_rdb;
  logic       o_alub;
  logic       o_drop;

  // reference model: pending slots plus the bytes of the response in flight
  logic        m_rdv;
  logic        m_aluv;
  logic        m_last_alu;
  logic        m_drop;
  logic [7:0]  m_rd;
  logic [15:0] m_alu;
  logic [7:0]  m_cur[$];
  logic        m_cur_alu;

  typedef struct {
    logic        rdv;
    logic [7:0]  rdd;
    logic        aluv;
    logic [15:0] alud;
    logic        full;
    logic        rst;
    logic        txv;
    logic [7:0]  txd;
    logic        rdb;
    logic        alub;
    logic        drop;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string nm, input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic exp_out(input string nm, input logic txv,
                         input logic [7:0] txd, input logic rdb,
                         input logic alub, input logic drop);
    chk({nm, ".txv"}, {15'd0, o_txv}, {15'd0, txv});
    chk({nm, ".txd"}, {8'd0, o_txd}, {8'd0, txd});
    chk({nm, ".rdb"}, {15'd0, o_rdb}, {15'd0, rdb});
    chk({nm, ".alub"}, {15'd0, o_alub}, {15'd0, alub});
    chk({nm, ".drop"}, {15'd0, o_drop}, {15'd0, drop});
  endtask

  task automatic model_out(input logic full, output logic txv,
                           output logic [7:0] txd, output logic rdb,
                           output logic alub, output logic drop);
    txv  = (m_cur.size() > 0) && !full;
    txd  = (m_cur.size() > 0) ? m_cur[0] : 8'h00;
    rdb  = m_rdv;
    alub = m_aluv;
    drop = m_drop;
  endtask

  task automatic model_step(input logic rdv, input logic [7:0] rdd,
                            input logic aluv, input logic [15:0] alud,
                            input logic full, input logic rst);
    logic rel_rd;
    logic rel_alu;
    logic pick_alu;
    if (rst) begin
      m_rdv      = 1'b0;
      m_aluv     = 1'b0;
      m_last_alu = 1'b1;
      m_drop     = 1'b0;
      m_cur.delete();
      return;
    end
    rel_rd  = 1'b0;
    rel_alu = 1'b0;
    if (m_cur.size() > 0) begin
      if (!full) begin
        void'(m_cur.pop_front());
        if (m_cur.size() == 0) begin
          if (m_cur_alu) rel_alu = 1'b1;
          else rel_rd = 1'b1;
        end
      end
    end else if (m_rdv || m_aluv) begin
      pick_alu   = (m_rdv && m_aluv) ? !m_last_alu : m_aluv;
      m_last_alu = pick_alu;
      m_cur_alu  = pick_alu;
      if (pick_alu) begin
        m_cur.push_back(m_alu[7:0]);
        m_cur.push_back(m_alu[15:8]);
      end else begin
        m_cur.push_back(m_rd);
      end
    end
    m_drop = (rdv && m_rdv && !rel_rd) || (aluv && m_aluv && !rel_alu);
    if (rdv && (!m_rdv || rel_rd)) begin
      m_rdv = 1'b1;
      m_rd  = rdd;
    end else if (rel_rd) begin
      m_rdv = 1'b0;
    end
    if (aluv && (!m_aluv || rel_alu)) begin
      m_aluv = 1'b1;
      m_alu  = alud;
    end else if (rel_alu) begin
      m_aluv = 1'b0;
    end
  endtask

  task automatic cyc(input logic rdv, input logic [7:0] rdd,
                     input logic aluv, input logic [15:0] alud,
                     input logic full, input logic rst);
    logic       e_txv;
    logic [7:0] e_txd;
    logic       e_rdb;
    logic       e_alub;
    logic       e_drop;
    bus.RD_DATA_VALID = rdv;
    bus.RD_DATA       = rdd;
    bus.ALU_OUT_VALID = aluv;
    bus.ALU_OUT       = alud;
    bus.FIFO_FULL     = full;
    RST               = rst;
    @(negedge CLK);
    o_txv  = bus.TX_DATA_VALID;
    o_txd  = bus.TX_P_DATA;
    o_rdb  = bus.RD_BUSY;
    o_alub = bus.ALU_BUSY;
    o_drop = bus.DROP_ERR;
    if (use_model) begin
      model_out(full, e_txv, e_txd, e_rdb, e_alub, e_drop);
      exp_out("rand", e_txv, e_txd, e_rdb, e_alub, e_drop);
    end
    model_step(rdv, rdd, aluv, alud, full, rst);
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input logic full);
    cyc(1'b0, 8'h00, 1'b0, 16'h0000, full, 1'b0);
  endtask

  task automatic do_reset();
    cyc(1'b0, 8'h00, 1'b0, 16'h0000, 1'b0, 1'b1);
  endtask

  initial begin
    bus.RD_DATA_VALID = 1'b0;
    bus.RD_DATA       = 8'h00;
    bus.ALU_OUT_VALID = 1'b0;
    bus.ALU_OUT       = 16'h0000;
    bus.FIFO_FULL     = 1'b0;
    @(posedge CLK);
    #1;
    do_reset();

    // reset state, single read, single ALU
    tbl[0] = '{0, 8'h00, 0, 16'h0000, 0, 1, 0, 8'h00, 0, 0, 0};
    tbl[1] = '{1, 8'h5A, 0, 16'h0000, 0, 0, 0, 8'h00, 0, 0, 0};
    tbl[2] = '{0, 8'h00, 0, 16'h0000, 0, 0, 0, 8'h00, 1, 0, 0};
    tbl[3] = '{0, 8'h00, 0, 16'h0000, 0, 0, 1, 8'h5A, 1, 0, 0};
    tbl[4] = '{0, 8'h00, 0, 16'h0000, 0, 0, 0, 8'h00, 0, 0, 0};
    tbl[5] = '{0, 8'h00, 1, 16'h1234, 0, 0, 0, 8'h00, 0, 0, 0};
    tbl[6] = '{0, 8'h00, 0, 16'h0000, 0, 0, 0, 8'h00, 0, 1, 0};
    tbl[7] = '{0, 8'h00, 0, 16'h0000, 0, 0, 1, 8'h34, 0, 1, 0};
    tbl[8] = '{0, 8'h00, 0, 16'h0000, 0, 0, 1, 8'h12, 0, 1, 0};
    tbl[9] = '{0, 8'h00, 0, 16'h0000, 0, 0, 0, 8'h00, 0, 0, 0};
    for (int i = 0; i < 10; i++) begin
      cyc(tbl[i].rdv, tbl[i].rdd, tbl[i].aluv, tbl[i].alud,
          tbl[i].full, tbl[i].rst);
      exp_out($sformatf("tbl%0d", i), tbl[i].txv, tbl[i].txd,
              tbl[i].rdb, tbl[i].alub, tbl[i].drop);
    end

    // backpressure on the low byte
    do_reset();
    cyc(1'b0, 8'h00, 1'b1, 16'hBEEF, 1'b0, 1'b0);
    exp_out("bp0", 0, 8'h00, 0, 0, 0);
    idle(1'b0);
    exp_out("bp1", 0, 8'h00, 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      idle(1'b1);
      exp_out($sformatf("bp_full%0d", i), 0, 8'hEF, 0, 1, 0);
    end
    idle(1'b0);
    exp_out("bp_lo", 1, 8'hEF, 0, 1, 0);
    idle(1'b0);
    exp_out("bp_hi", 1, 8'hBE, 0, 1, 0);
    idle(1'b0);
    exp_out("bp_end", 0, 8'h00, 0, 0, 0);

    // contention and round-robin fairness
    do_reset();
    cyc(1'b1, 8'h11, 1'b1, 16'hAA55, 1'b0, 1'b0);
    exp_out("ct0", 0, 8'h00, 0, 0, 0);
    idle(1'b0);
    exp_out("ct1", 0, 8'h00, 1, 1, 0);
    idle(1'b0);
    exp_out("ct_rd", 1, 8'h11, 1, 1, 0);
    idle(1'b0);
    exp_out("ct_gap", 0, 8'h00, 0, 1, 0);
    idle(1'b0);
    exp_out("ct_lo", 1, 8'h55, 0, 1, 0);
    idle(1'b0);
    exp_out("ct_hi", 1, 8'hAA, 0, 1, 0);
    cyc(1'b1, 8'h33, 1'b0, 16'h0000, 1'b0, 1'b0);
    exp_out("ct_gap2", 0, 8'h00, 0, 0, 0);
    idle(1'b0);
    exp_out("ct_rd33w", 0, 8'h00, 1, 0, 0);
    idle(1'b0);
    exp_out("ct_rd33", 1, 8'h33, 1, 0, 0);
    cyc(1'b1, 8'h22, 1'b1, 16'hCDEF, 1'b0, 1'b0);
    exp_out("ct2_0", 0, 8'h00, 0, 0, 0);
    idle(1'b0);
    exp_out("ct2_1", 0, 8'h00, 1, 1, 0);
    idle(1'b0);
    exp_out("ct2_lo", 1, 8'hEF, 1, 1, 0);
    idle(1'b0);
    exp_out("ct2_hi", 1, 8'hCD, 1, 1, 0);
    idle(1'b0);
    exp_out("ct2_gap", 0, 8'h00, 1, 0, 0);
    idle(1'b0);
    exp_out("ct2_rd", 1, 8'h22, 1, 0, 0);
    idle(1'b0);
    exp_out("ct2_end", 0, 8'h00, 0, 0, 0);

    // drop while occupied, then accept on the release edge
    do_reset();
    cyc(1'b1, 8'h66, 1'b0, 16'h0000, 1'b1, 1'b0);
    exp_out("dr0", 0, 8'h00, 0, 0, 0);
    idle(1'b1);
    exp_out("dr1", 0, 8'h00, 1, 0, 0);
    cyc(1'b1, 8'h77, 1'b0, 16'h0000, 1'b1, 1'b0);
    exp_out("dr_strb", 0, 8'h66, 1, 0, 0);
    idle(1'b1);
    exp_out("dr_pulse", 0, 8'h66, 1, 0, 1);
    idle(1'b1);
    exp_out("dr_after", 0, 8'h66, 1, 0, 0);
    cyc(1'b1, 8'h88, 1'b0, 16'h0000, 1'b0, 1'b0);
    exp_out("dr_xfer", 1, 8'h66, 1, 0, 0);
    idle(1'b0);
    exp_out("dr_gap", 0, 8'h00, 1, 0, 0);
    idle(1'b0);
    exp_out("dr_88", 1, 8'h88, 1, 0, 0);
    idle(1'b0);
    exp_out("dr_end", 0, 8'h00, 0, 0, 0);

    // reset in the middle of an ALU response
    do_reset();
    cyc(1'b0, 8'h00, 1'b1, 16'h4321, 1'b0, 1'b0);
    idle(1'b0);
    exp_out("rs1", 0, 8'h00, 0, 1, 0);
    idle(1'b0);
    exp_out("rs_lo", 1, 8'h21, 0, 1, 0);
    cyc(1'b0, 8'h00, 1'b0, 16'h0000, 1'b1, 1'b1);
    exp_out("rs_hi", 0, 8'h43, 0, 1, 0);
    idle(1'b1);
    exp_out("rs_after", 0, 8'h00, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      idle(1'b0);
      exp_out($sformatf("rs_quiet%0d", i), 0, 8'h00, 0, 0, 0);
    end

    // random traffic against the reference model
    do_reset();
    use_model = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(99) < 30, 8'($urandom),
          $urandom_range(99) < 25, 16'($urandom),
          $urandom_range(99) < 30, $urandom_range(199) == 0);
    end
    use_model = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
